// File: rtl/nova_cfg_sequencer.sv
// nova_cfg_sequencer: streams host config words onto the NovaCORE config
// port, strobing c_clk per word and owning the fabric run/config mode.
module nova_cfg_sequencer #(
   parameter int BUS_W     = 42,
   parameter int UID_W     = 7,
   parameter int NUM_CELLS = 25,
   parameter int CLK_LO    = 2,
   parameter int CLK_HI    = 2,
   parameter int SETTLE    = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_words,
   input  logic             abort,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [BUS_W-1:0] cfg_data,
   input  logic [UID_W-1:0] cfg_uid,
   output logic             mode,
   output logic [BUS_W-1:0] c_bus,
   output logic [UID_W-1:0] c_uid,
   output logic             c_clk,
   output logic             busy,
   output logic             done,
   output logic             err_uid,
   output logic             err_abort
);

   localparam int TMAX0 = (CLK_LO > CLK_HI) ? CLK_LO : CLK_HI;
   localparam int TMAX  = (TMAX0 > SETTLE) ? TMAX0 : SETTLE;
   localparam int TMR_W = $clog2(TMAX + 1);

   localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE - 1);
   localparam logic [TMR_W-1:0] LO_END     = TMR_W'(CLK_LO - 1);
   localparam logic [TMR_W-1:0] HI_END     = TMR_W'(CLK_HI - 1);

   typedef enum logic [2:0] {
      IDLE,
      ENTER,
      WAIT,
      SETUP,
      PULSE,
      HOLD,
      EXIT
   } state_t;

   state_t           state;
   logic [TMR_W-1:0] tmr;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] n_lat;
   logic [CNT_W-1:0] cnt_nx;
   logic             uid_ok;
   logic             accept;
   logic             abort_ok;

   assign cnt_nx   = cnt + CNT_W'(1);
   assign uid_ok   = {1'b0, cfg_uid} < (UID_W + 1)'(NUM_CELLS);
   assign accept   = cfg_valid && cfg_ready;
   assign abort_ok = abort && (state != IDLE) && (state != EXIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tmr       <= '0;
         cnt       <= '0;
         n_lat     <= '0;
         mode      <= 1'b0;
         c_bus     <= '0;
         c_uid     <= '0;
         c_clk     <= 1'b0;
         cfg_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_uid   <= 1'b0;
         err_abort <= 1'b0;
      end else begin
         done <= 1'b0;
         // abort drops the in-flight word: cnt is left untouched
         if (abort_ok) begin
            c_clk     <= 1'b0;
            cfg_ready <= 1'b0;
            mode      <= 1'b0;
            err_abort <= 1'b1;
            tmr       <= '0;
            state     <= EXIT;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     n_lat     <= n_words;
                     cnt       <= '0;
                     err_uid   <= 1'b0;
                     err_abort <= 1'b0;
                     mode      <= 1'b1;
                     busy      <= 1'b1;
                     tmr       <= '0;
                     state     <= ENTER;
                  end
               end
               ENTER: begin
                  if (tmr == SETTLE_END) begin
                     tmr <= '0;
                     if (n_lat != '0) begin
                        cfg_ready <= 1'b1;
                        state     <= WAIT;
                     end else begin
                        mode  <= 1'b0;
                        state <= EXIT;
                     end
                  end else begin
                     tmr <= tmr + TMR_W'(1);
                  end
               end
               WAIT: begin
                  if (accept) begin
                     if (uid_ok) begin
                        c_bus     <= cfg_data;
                        c_uid     <= cfg_uid;
                        cfg_ready <= 1'b0;
                        tmr       <= '0;
                        state     <= SETUP;
                     end else begin
                        err_uid <= 1'b1;
                        cnt     <= cnt_nx;
                        if (cnt_nx == n_lat) begin
                           cfg_ready <= 1'b0;
                           mode      <= 1'b0;
                           tmr       <= '0;
                           state     <= EXIT;
                        end
                     end
                  end
               end
               SETUP: begin
                  if (tmr == LO_END) begin
                     c_clk <= 1'b1;
                     tmr   <= '0;
                     state <= PULSE;
                  end else begin
                     tmr <= tmr + TMR_W'(1);
                  end
               end
               PULSE: begin
                  if (tmr == HI_END) begin
                     c_clk <= 1'b0;
                     tmr   <= '0;
                     state <= HOLD;
                  end else begin
                     tmr <= tmr + TMR_W'(1);
                  end
               end
               HOLD: begin
                  cnt <= cnt_nx;
                  tmr <= '0;
                  if (cnt_nx == n_lat) begin
                     mode  <= 1'b0;
                     state <= EXIT;
                  end else begin
                     cfg_ready <= 1'b1;
                     state     <= WAIT;
                  end
               end
               EXIT: begin
                  if (tmr == SETTLE_END) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     tmr   <= '0;
                     state <= IDLE;
                  end else begin
                     tmr <= tmr + TMR_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nova_cfg_sequencer.sv
// tb_nova_cfg_sequencer: random frames driven into nova_cfg_sequencer and
// compared against an event-level model of strobes, timing and flags.
module tb_nova_cfg_sequencer;

   localparam int BUS_W     = 42;
   localparam int UID_W     = 7;
   localparam int NUM_CELLS = 25;
   localparam int CLK_LO    = 2;
   localparam int CLK_HI    = 2;
   localparam int SETTLE    = 4;
   localparam int CNT_W     = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] n_words;
   logic             abort;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [BUS_W-1:0] cfg_data;
   logic [UID_W-1:0] cfg_uid;
   logic             mode;
   logic [BUS_W-1:0] c_bus;
   logic [UID_W-1:0] c_uid;
   logic             c_clk;
   logic             busy;
   logic             done;
   logic             err_uid;
   logic             err_abort;

   nova_cfg_sequencer #(
      .BUS_W(BUS_W), .UID_W(UID_W), .NUM_CELLS(NUM_CELLS),
      .CLK_LO(CLK_LO), .CLK_HI(CLK_HI), .SETTLE(SETTLE), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .n_words(n_words),
      .abort(abort), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_data(cfg_data), .cfg_uid(cfg_uid), .mode(mode),
      .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk), .busy(busy),
      .done(done), .err_uid(err_uid), .err_abort(err_abort)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // event monitor: what the fabric port actually did
   bit               mon_clr = 1'b0;
   bit               ab_flag = 1'b0;
   bit               prev_clk, prev_mode;
   int               hi_len;
   int               rise_cyc_q[$];
   logic [BUS_W-1:0] rise_bus_q[$];
   logic [UID_W-1:0] rise_uid_q[$];
   int               width_q[$];
   int               unstable, done_cnt, done_cyc;
   int               mode_rise, mode_fall, ready_cnt, ready_post_ab;
   logic [BUS_W-1:0] cur_bus;
   logic [UID_W-1:0] cur_uid;

   always @(negedge clk) begin
      if (mon_clr) begin
         rise_cyc_q.delete();
         rise_bus_q.delete();
         rise_uid_q.delete();
         width_q.delete();
         unstable = 0; done_cnt = 0; done_cyc = 0; hi_len = 0;
         mode_rise = -1; mode_fall = -1; ready_cnt = 0; ready_post_ab = 0;
         prev_clk = c_clk; prev_mode = mode;
      end else begin
         if (c_clk && !prev_clk) begin
            rise_cyc_q.push_back(cyc);
            rise_bus_q.push_back(c_bus);
            rise_uid_q.push_back(c_uid);
            cur_bus = c_bus;
            cur_uid = c_uid;
            hi_len = 1;
         end else if (c_clk) begin
            hi_len++;
            if (c_bus !== cur_bus || c_uid !== cur_uid) unstable++;
         end else if (prev_clk) begin
            width_q.push_back(hi_len);
         end
         if (mode && !prev_mode) mode_rise = cyc;
         if (!mode && prev_mode) mode_fall = cyc;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cfg_ready) begin
            ready_cnt++;
            if (ab_flag) ready_post_ab++;
         end
         prev_clk = c_clk;
         prev_mode = mode;
      end
   end

   // reference: accepted words in order, with their accept cycles
   int               uid_tab[$];
   logic [BUS_W-1:0] exp_bus_q[$];
   logic [UID_W-1:0] exp_uid_q[$];
   int               exp_cyc_q[$];

   task automatic next_word(input int idx, input int bad_pct,
                            output logic [BUS_W-1:0] d,
                            output logic [UID_W-1:0] u);
      d = BUS_W'({$urandom(), $urandom()});
      if (idx < uid_tab.size())
         u = UID_W'(uid_tab[idx]);
      else if ($urandom_range(0, 99) < bad_pct)
         u = UID_W'($urandom_range(NUM_CELLS, (1 << UID_W) - 1));
      else
         u = UID_W'($urandom_range(0, NUM_CELLS - 1));
   endtask

   task automatic run_frame(input int n, input int gap_max, input int bad_pct,
                            input int abort_k, input bit abort_w_start);
      int idx, gap, budget, drv_rise, la, s_cyc, nmin;
      bit last_c, acc, ab, ab_pend, eu, last_bad;
      logic [BUS_W-1:0] d;
      logic [UID_W-1:0] u;
      exp_bus_q.delete();
      exp_uid_q.delete();
      exp_cyc_q.delete();
      ab_flag = 1'b0;
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
      start = 1'b1;
      n_words = CNT_W'(n);
      abort = abort_w_start;
      s_cyc = cyc;
      tick();
      start = 1'b0;
      abort = 1'b0;
      idx = 0; budget = 0; drv_rise = 0; la = 0;
      last_c = 1'b0; ab = 1'b0; ab_pend = 1'b0; eu = 1'b0; last_bad = 1'b0;
      gap = $urandom_range(0, gap_max);
      next_word(idx, bad_pct, d, u);
      while (done_cnt == 0 && budget < 4000) begin
         abort = 1'b0;
         if (ab_pend) begin
            chk("abort_cclk", c_clk, 0);
            chk("abort_mode", mode, 0);
            chk("abort_flag", err_abort, 1);
            ab_pend = 1'b0;
         end
         if (c_clk && !last_c) drv_rise++;
         last_c = c_clk;
         start = 1'b0;
         if (busy && $urandom_range(0, 3) == 0) begin
            start = 1'b1;
            n_words = CNT_W'($urandom());
         end
         acc = 1'b0;
         if (!ab && abort_k != 0 && c_clk && drv_rise == abort_k) begin
            abort = 1'b1;
            ab = 1'b1;
            ab_pend = 1'b1;
            ab_flag = 1'b1;
            cfg_valid = 1'b0;
         end else if (!ab && idx < n && gap == 0) begin
            cfg_valid = 1'b1;
            cfg_data = d;
            cfg_uid = u;
            acc = cfg_ready;
         end else begin
            cfg_valid = 1'b0;
            cfg_data = BUS_W'({$urandom(), $urandom()});
            cfg_uid = UID_W'($urandom());
            if (gap > 0) gap--;
         end
         if (acc) begin
            last_bad = int'(u) >= NUM_CELLS;
            if (last_bad) begin
               eu = 1'b1;
            end else begin
               exp_bus_q.push_back(d);
               exp_uid_q.push_back(u);
               exp_cyc_q.push_back(cyc);
            end
            la = cyc;
            idx++;
            gap = $urandom_range(0, gap_max);
            next_word(idx, bad_pct, d, u);
         end
         tick();
         budget++;
      end
      start = 1'b0;
      abort = 1'b0;
      cfg_valid = 1'b0;
      chk("frame_done", done_cnt != 0, 1);
      repeat (3) tick();
      chk("done_once", done_cnt, 1);
      chk("pulses", rise_cyc_q.size(), exp_cyc_q.size());
      nmin = (rise_cyc_q.size() < exp_cyc_q.size()) ?
             rise_cyc_q.size() : exp_cyc_q.size();
      for (int i = 0; i < nmin; i++) begin
         chk("pulse_bus", rise_bus_q[i], exp_bus_q[i]);
         chk("pulse_uid", rise_uid_q[i], exp_uid_q[i]);
         chk("pulse_rise", rise_cyc_q[i], exp_cyc_q[i] + 1 + CLK_LO);
      end
      for (int i = 0; i < width_q.size(); i++)
         if (!(ab && i == width_q.size() - 1))
            chk("pulse_width", width_q[i], CLK_HI);
      chk("bus_stable", unstable, 0);
      chk("mode_rise", mode_rise, s_cyc + 1);
      chk("exit_settle", done_cyc - mode_fall, SETTLE);
      chk("err_uid", err_uid, eu);
      chk("err_abort", err_abort, ab);
      chk("busy_idle", busy, 0);
      chk("mode_idle", mode, 0);
      if (ab)
         chk("ready_post_abort", ready_post_ab, 0);
      else if (n == 0) begin
         chk("n0_ready", ready_cnt, 0);
         chk("n0_mode_len", mode_fall - mode_rise, SETTLE);
      end else
         chk("exit_time", mode_fall,
             la + (last_bad ? 1 : CLK_LO + CLK_HI + 2));
   endtask

   task automatic run_reset_mid();
      int b;
      ab_flag = 1'b0;
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
      start = 1'b1;
      n_words = CNT_W'(3);
      tick();
      start = 1'b0;
      cfg_valid = 1'b1;
      cfg_data = BUS_W'({$urandom(), $urandom()}) | BUS_W'(1);
      cfg_uid = UID_W'(5);
      b = 0;
      while (!cfg_ready && b < 100) begin
         tick();
         b++;
      end
      chk("rst_reach_wait", cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mode", mode, 0);
      chk("rst_cclk", c_clk, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_cbus", c_bus, 0);
      repeat (4) tick();
      chk("rst_no_pulse", rise_cyc_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      n_words = '0;
      abort = 1'b0;
      cfg_valid = 1'b0;
      cfg_data = '0;
      cfg_uid = '0;
      repeat (3) tick();
      chk("rst_mode", mode, 0);
      chk("rst_cclk", c_clk, 0);
      chk("rst_cbus", c_bus, 0);
      chk("rst_cuid", c_uid, 0);
      chk("rst_ready", cfg_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_uid", err_uid, 0);
      chk("rst_err_abort", err_abort, 0);
      rst = 1'b0;
      tick();

      uid_tab = '{0, 12, 24};
      run_frame(3, 0, 0, 0, 1'b0);
      uid_tab.delete();
      run_frame(0, 0, 0, 0, 1'b0);
      uid_tab = '{3, 25, 4};
      run_frame(3, 0, 0, 0, 1'b0);
      uid_tab.delete();
      run_frame(5, 0, 0, 2, 1'b0);
      for (int k = 0; k < 4; k++)
         run_frame($urandom_range(1, 12), 7, 20, 0, 1'b0);
      run_reset_mid();
      run_frame(4, 3, 0, 0, 1'b0);
      run_frame(2, 0, 0, 0, 1'b1);
      run_frame(255, 0, 10, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
